mul_share_arbiter: RTL and testbench
====================================

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 Parameter: W, 8, operand width of each requester and of the shared multiplier.
REQ-002 Parameter: TIMEOUT, 31, maximum WAIT cycles allowed before the multiplier is declared hung.
REQ-003 Ports shall be, in order, as follows.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req0_ready  out  1  requester 0 operand pair accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 is held.
- rsp0_p  out  2W  requester 0 product.
- rsp0_err  out  1  requester 0 result is a timeout.
- rsp0_ack  in  1  requester 0 consumes its result.
- rsp1_valid, rsp1_p, rsp1_err, rsp1_ack  same as requester 0, for requester 1.
- mul_start  out  1  one-cycle start pulse to the shared multiplier.
- mul_a  out  W  multiplier operand A.
- mul_b  out  W  multiplier operand B.
- mul_done  in  1  multiplier result-valid pulse.
- mul_p  in  2W  multiplier product.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-004 FSM states shall be IDLE, ISSUE and WAIT, all registered.
REQ-005 IDLE: requester N shall be eligible when reqN_valid=1 and rspN_valid=0 (its result slot is free).
REQ-006 Arbitration shall be round-robin:
- if both requesters are eligible, grant the one not equal to last_grant;
- if only one is eligible, grant it.
REQ-007 reqN_ready shall be combinational, high only in IDLE, and only for the granted requester; the other requester's ready stays 0.
REQ-008 Handshake: on reqN_valid & reqN_ready, the block shall:
- latch reqN_a into mul_a and reqN_b into mul_b;
- record owner=N and set last_grant=N;
- go to ISSUE.
REQ-009 ISSUE: mul_start=1 for exactly this one cycle; clear the wait counter; go to WAIT.
REQ-010 mul_a and mul_b shall remain stable from ISSUE until the return to IDLE.
REQ-011 WAIT, mul_done=1: rsp[owner]_p<=mul_p, rsp[owner]_err<=0, rsp[owner]_valid<=1; go to IDLE.
REQ-012 WAIT, mul_done=0: increment the wait counter.
REQ-013 WAIT timeout: when the counter equals TIMEOUT-1 and mul_done=0, rsp[owner]_p<=0, rsp[owner]_err<=1, rsp[owner]_valid<=1; go to IDLE.
REQ-014 The wait counter shall be wide enough to hold TIMEOUT without wrap.
REQ-015 mul_done in IDLE or ISSUE shall be ignored; it causes no state or output change.
REQ-016 rspN_valid, rspN_p and rspN_err shall hold until the rising edge where rspN_valid & rspN_ack; rspN_valid clears on that edge.
REQ-017 rspN_ack while rspN_valid=0 shall be ignored.
REQ-018 A requester with a pending result shall never be granted; the other requester may be granted in the same cycle.
REQ-019 Ack of rspN in the cycle IDLE evaluates eligibility: requester N is still ineligible that cycle and becomes eligible the next cycle.
REQ-020 Latency: accept at edge T, mul_start high in cycle T+1, result visible the cycle after the edge sampling mul_done.
REQ-021 Products shall pass through unmodified (2W bits); the block performs no arithmetic on data.

Reset
REQ-022 While reset=1, asynchronously:
- state=IDLE, last_grant=1 (requester 0 wins the first tie);
- all rsp*_valid, rsp*_p, rsp*_err=0;
- mul_start=0, mul_a=0, mul_b=0, counter=0, busy=0;
- req*_ready=0.
REQ-023 Reset during ISSUE or WAIT shall abandon the operation without producing a response; a later stray mul_done shall be ignored per REQ-015.

Verification
REQ-024 Single op: req0 a=8'd3, b=8'd5; model asserts mul_done with mul_p=16'd15 17 cycles after mul_start -> rsp0_valid=1, rsp0_p=16'h000F, rsp0_err=0; mul_start seen exactly once.
REQ-025 Tie after reset: req0 (7,9) and req1 (2,4) valid together -> req0 accepted first, rsp0_p=63; then req1 accepted, rsp1_p=8; exactly two mul_start pulses.
REQ-026 Backpressure: rsp0 held with rsp0_ack=0; req0 and req1 both valid -> only req1 granted; req0 granted only the cycle after rsp0 ack.
REQ-027 Timeout: mul_done never asserted -> exactly 31 WAIT cycles, then rsp0_valid=1, rsp0_err=1, rsp0_p=0, busy=0.
REQ-028 Reset mid-WAIT: assert reset 5 cycles after mul_start, then pulse mul_done -> all outputs 0, no rsp*_valid, state IDLE.
REQ-029 Stray mul_done in IDLE -> no output change; mul_a and mul_b stable throughout every WAIT.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one external multiplier between two requesters. Requests are
//   granted round-robin in IDLE, the operands are held on mul_a/mul_b for
//   the whole operation, mul_start pulses once, and the product (or a
//   timeout error) is parked in the owner's response slot until acked.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   reqN_valid/a/b, reqN_ready operand handshake for requester N (0/1)
//   rspN_valid/p/err, rspN_ack held result for requester N
//   mul_start, mul_a, mul_b    command side of the shared multiplier
//   mul_done, mul_p            result side of the shared multiplier
//   busy                       high whenever an operation is in flight
module mul_share_arbiter #(
  parameter int W       = 8,
  parameter int TIMEOUT = 31
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           rsp0_valid,
  output logic [2*W-1:0] rsp0_p,
  output logic           rsp0_err,
  input  logic           rsp0_ack,
  output logic           rsp1_valid,
  output logic [2*W-1:0] rsp1_p,
  output logic           rsp1_err,
  input  logic           rsp1_ack,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_p,
  output logic           busy
);

  // Counter must be able to represent TIMEOUT itself without wrapping.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           owner_q, owner_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   mul_a_q, mul_a_d;
  logic [W-1:0]   mul_b_q, mul_b_d;
  logic           rsp0_valid_q, rsp0_valid_d;
  logic [2*W-1:0] rsp0_p_q, rsp0_p_d;
  logic           rsp0_err_q, rsp0_err_d;
  logic           rsp1_valid_q, rsp1_valid_d;
  logic [2*W-1:0] rsp1_p_q, rsp1_p_d;
  logic           rsp1_err_q, rsp1_err_d;

  logic elig0, elig1, grant0, grant1, in_idle;

  // A requester whose result slot is still occupied is never eligible, so
  // an ack in the same cycle only frees it for the following cycle.
  assign elig0   = req0_valid & ~rsp0_valid_q;
  assign elig1   = req1_valid & ~rsp1_valid_q;
  // On a tie the requester that did not win last time gets the grant.
  assign grant0  = elig0 & (~elig1 | last_grant_q);
  assign grant1  = elig1 & (~elig0 | ~last_grant_q);
  assign in_idle = (state_q == IDLE);

  // Ready is also masked by reset so it reads 0 while reset is held.
  assign req0_ready = in_idle & grant0 & ~reset;
  assign req1_ready = in_idle & grant1 & ~reset;

  assign mul_start  = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_p     = rsp0_p_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_p     = rsp1_p_q;
  assign rsp1_err   = rsp1_err_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_p_d     = rsp0_p_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_p_d     = rsp1_p_q;
    rsp1_err_d   = rsp1_err_q;

    // Consumption of a held result; ack without a valid result is a no-op.
    if (rsp0_valid_q && rsp0_ack) rsp0_valid_d = 1'b0;
    if (rsp1_valid_q && rsp1_ack) rsp1_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          mul_a_d      = req0_a;
          mul_b_d      = req0_b;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = ISSUE;
        end else if (req1_ready) begin
          mul_a_d      = req1_a;
          mul_b_d      = req1_b;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // The owner's slot was free at grant time, so it is still free here
        // and cannot collide with a same-cycle ack.
        if (mul_done) begin
          if (owner_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_p_d     = mul_p;
            rsp1_err_d   = 1'b0;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_p_d     = mul_p;
            rsp0_err_d   = 1'b0;
          end
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          if (owner_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_p_d     = '0;
            rsp1_err_d   = 1'b1;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_p_d     = '0;
            rsp0_err_d   = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_p_q     <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_p_q     <= '0;
      rsp1_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_p_q     <= rsp0_p_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_p_q     <= rsp1_p_d;
      rsp1_err_q   <= rsp1_err_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//   Scenario tasks drive the arbiter against a behavioural multiplier;
//   expected responses are queued when a request is driven and popped when
//   the matching response slot becomes valid.
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [15:0] rsp0_p, rsp1_p;
  logic        rsp0_ack = 1'b0, rsp1_ack = 1'b0;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        mul_done = 1'b0;
  logic [15:0] mul_p = '0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];

  // Multiplier model state
  bit          mdl_hang = 1'b0;
  int          mdl_cnt = 0;
  int          mdl_starts = 0;
  int          mdl_pulse_cnt = 0;
  int          mdl_pulse_seen = 0;
  logic [15:0] mdl_prod = '0;

  mul_share_arbiter #(.W(8), .TIMEOUT(31)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_p(rsp0_p), .rsp0_err(rsp0_err), .rsp0_ack(rsp0_ack),
    .rsp1_valid(rsp1_valid), .rsp1_p(rsp1_p), .rsp1_err(rsp1_err), .rsp1_ack(rsp1_ack),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Multiplier: done pulses 17 cycles after the cycle carrying mul_start.
  initial forever begin
    @(negedge clk);
    mul_done = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mul_done = 1'b1;
        mul_p    = mdl_prod;
      end
    end
    if (mdl_pulse_cnt != mdl_pulse_seen) begin
      mdl_pulse_seen = mdl_pulse_cnt;
      mul_done = 1'b1;
      mul_p    = 16'hBEEF;
    end
    if (mul_start === 1'b1) begin
      mdl_starts++;
      if (!mdl_hang) begin
        mdl_cnt  = 17;
        mdl_prod = 16'(mul_a) * 16'(mul_b);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one request and returns at the negedge of the ISSUE cycle.
  task automatic accept(input bit n, input logic [7:0] a, input logic [7:0] b, output bit ok);
    int k;
    @(negedge clk);
    if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    k = 0;
    while (((n ? req1_ready : req0_ready) !== 1'b1) && k < 100) begin
      @(negedge clk); #1; k++;
    end
    ok = (k < 100);
    @(negedge clk);
    if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Waits for rspN_valid, tracking operand stability while busy.
  task automatic wait_rsp(input bit n, input logic [7:0] ea, input logic [7:0] eb,
                          output int cycles, output bit stable);
    cycles = 0;
    stable = 1'b1;
    while (((n ? rsp1_valid : rsp0_valid) !== 1'b1) && cycles < 200) begin
      if (busy === 1'b1 && (mul_a !== ea || mul_b !== eb)) stable = 1'b0;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic ack_rsp(input bit a0, input bit a1);
    @(negedge clk);
    rsp0_ack = a0; rsp1_ack = a1;
    @(negedge clk);
    rsp0_ack = 1'b0; rsp1_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_tests++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
    n_tests++; if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 4'b0) begin n_fail++; $display("FAIL reset_rsp_flags: got %b want 0000", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}); end
    n_tests++; if ({rsp0_p, rsp1_p} !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_p: got %h want 0", {rsp0_p, rsp1_p}); end
    n_tests++; if ({mul_start, busy, mul_a, mul_b} !== 18'h0) begin n_fail++; $display("FAIL reset_mul: got %h want 0", {mul_start, busy, mul_a, mul_b}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    bit ok, stable; int cyc; int s0; logic [16:0] e;
    s0 = mdl_starts;
    exp_q0.push_back({1'b0, 16'd15});
    accept(1'b0, 8'd3, 8'd5, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_ready: no req0_ready within bound"); end
    n_tests++; if ({mul_start, busy, mul_a, mul_b} !== {1'b1, 1'b1, 8'd3, 8'd5}) begin n_fail++; $display("FAIL single_issue: got %h want %h", {mul_start, busy, mul_a, mul_b}, {1'b1, 1'b1, 8'd3, 8'd5}); end
    wait_rsp(1'b0, 8'd3, 8'd5, cyc, stable);
    n_tests++; if (cyc !== 18) begin n_fail++; $display("FAIL single_latency: got %0d want 18 cycles", cyc); end
    n_tests++; if (!stable) begin n_fail++; $display("FAIL single_stable: operands changed during WAIT"); end
    e = exp_q0.pop_front();
    n_tests++; if ({rsp0_err, rsp0_p} !== e) begin n_fail++; $display("FAIL single_rsp: got %h want %h", {rsp0_err, rsp0_p}, e); end
    n_tests++; if (busy !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b rsp1_valid=%b want 0 0", busy, rsp1_valid); end
    n_tests++; if (mdl_starts - s0 !== 1) begin n_fail++; $display("FAIL single_starts: got %0d want 1", mdl_starts - s0); end
    ack_rsp(1'b1, 1'b0);
    n_tests++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack: rsp0_valid got %b want 0", rsp0_valid); end
    $display("[TB] single op 3*5 p=%h", rsp0_p);
  endtask

  task automatic test_tie();
    bit stable; int cyc; int s0; logic [16:0] e;
    do_reset();
    s0 = mdl_starts;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd9;
    req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd4;
    exp_q0.push_back({1'b0, 16'd63});
    exp_q1.push_back({1'b0, 16'd8});
    #1;
    n_tests++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL tie_first_grant: got %b want 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(1'b0, 8'd7, 8'd9, cyc, stable);
    e = exp_q0.pop_front();
    n_tests++; if ({rsp0_err, rsp0_p} !== e || cyc >= 200 || !stable) begin n_fail++; $display("FAIL tie_rsp0: got %h want %h cyc=%0d stable=%b", {rsp0_err, rsp0_p}, e, cyc, stable); end
    n_tests++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL tie_second_grant: got %b want 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(1'b1, 8'd2, 8'd4, cyc, stable);
    e = exp_q1.pop_front();
    n_tests++; if ({rsp1_err, rsp1_p} !== e || cyc >= 200 || !stable) begin n_fail++; $display("FAIL tie_rsp1: got %h want %h cyc=%0d stable=%b", {rsp1_err, rsp1_p}, e, cyc, stable); end
    n_tests++; if (mdl_starts - s0 !== 2) begin n_fail++; $display("FAIL tie_starts: got %0d want 2", mdl_starts - s0); end
    ack_rsp(1'b1, 1'b1);
    $display("[TB] tie rsp0=%0d rsp1=%0d", rsp0_p, rsp1_p);
  endtask

  task automatic test_back_to_back();
    bit ok, stable; int cyc; logic [16:0] e;
    do_reset();
    exp_q0.push_back({1'b0, 16'd42});
    accept(1'b0, 8'd6, 8'd7, ok);
    wait_rsp(1'b0, 8'd6, 8'd7, cyc, stable);
    e = exp_q0.pop_front();
    n_tests++; if ({rsp0_err, rsp0_p} !== e || !ok) begin n_fail++; $display("FAIL bp_first: got %h want %h", {rsp0_err, rsp0_p}, e); end
    exp_q1.push_back({1'b0, 16'd6});
    accept(1'b1, 8'd2, 8'd3, ok);
    wait_rsp(1'b1, 8'd2, 8'd3, cyc, stable);
    e = exp_q1.pop_front();
    n_tests++; if ({rsp1_err, rsp1_p} !== e || !ok) begin n_fail++; $display("FAIL bp_second: got %h want %h", {rsp1_err, rsp1_p}, e); end
    ack_rsp(1'b0, 1'b1);
    // rsp0 still pending, last grant was requester 1
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'd4; req0_b = 8'd4;
    req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd6;
    exp_q1.push_back({1'b0, 16'd30});
    #1;
    n_tests++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_grant: got %b want 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(1'b1, 8'd5, 8'd6, cyc, stable);
    e = exp_q1.pop_front();
    n_tests++; if ({rsp1_err, rsp1_p} !== e || !stable) begin n_fail++; $display("FAIL bp_rsp1: got %h want %h stable=%b", {rsp1_err, rsp1_p}, e, stable); end
    rsp0_ack = 1'b1;
    #1;
    n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ack_same_cycle: req0_ready got %b want 0", req0_ready); end
    @(negedge clk);
    rsp0_ack = 1'b0;
    exp_q0.push_back({1'b0, 16'd16});
    #1;
    n_tests++; if ({rsp0_valid, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_ack_next_cycle: valid,ready got %b want 01", {rsp0_valid, req0_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(1'b0, 8'd4, 8'd4, cyc, stable);
    e = exp_q0.pop_front();
    n_tests++; if ({rsp0_err, rsp0_p} !== e || !stable || cyc >= 200) begin n_fail++; $display("FAIL bp_rsp0: got %h want %h", {rsp0_err, rsp0_p}, e); end
    ack_rsp(1'b1, 1'b1);
    $display("[TB] backpressure rsp0=%0d", rsp0_p);
  endtask

  task automatic test_timeout();
    bit ok, stable; int cyc; logic [16:0] e;
    mdl_hang = 1'b1;
    exp_q0.push_back({1'b1, 16'd0});
    accept(1'b0, 8'd9, 8'd9, ok);
    wait_rsp(1'b0, 8'd9, 8'd9, cyc, stable);
    n_tests++; if (cyc !== 32) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 32 (ISSUE + 31 WAIT)", cyc); end
    e = exp_q0.pop_front();
    n_tests++; if ({rsp0_err, rsp0_p} !== e) begin n_fail++; $display("FAIL timeout_rsp: got %h want %h", {rsp0_err, rsp0_p}, e); end
    n_tests++; if (busy !== 1'b0 || !stable) begin n_fail++; $display("FAIL timeout_busy: busy=%b stable=%b want 0 1", busy, stable); end
    ack_rsp(1'b1, 1'b0);
    mdl_hang = 1'b0;
    $display("[TB] timeout err=%b", rsp0_err);
  endtask

  task automatic test_reset_mid_wait();
    bit ok; bit clean;
    mdl_hang = 1'b1;
    accept(1'b1, 8'd3, 8'd3, ok);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++; if ({busy, mul_start, mul_a, mul_b, rsp1_valid} !== 19'h0) begin n_fail++; $display("FAIL rmw_in_reset: got %h want 0", {busy, mul_start, mul_a, mul_b, rsp1_valid}); end
    @(negedge clk);
    reset = 1'b0;
    mdl_pulse_cnt++;
    clean = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if ({busy, mul_start, rsp0_valid, rsp1_valid, rsp0_p, rsp1_p, mul_a, mul_b} !== 52'h0) clean = 1'b0;
    end
    n_tests++; if (!clean || !ok) begin n_fail++; $display("FAIL rmw_stray_done: outputs changed after reset, busy=%b rsp1_valid=%b", busy, rsp1_valid); end
    mdl_hang = 1'b0;
    $display("[TB] reset mid-WAIT abandoned op");
  endtask

  task automatic test_stray_done();
    bit ok, stable, clean; int cyc; logic [16:0] e;
    do_reset();
    exp_q0.push_back({1'b0, 16'd143});
    accept(1'b0, 8'd11, 8'd13, ok);
    wait_rsp(1'b0, 8'd11, 8'd13, cyc, stable);
    e = exp_q0.pop_front();
    n_tests++; if ({rsp0_err, rsp0_p} !== e || !stable) begin n_fail++; $display("FAIL stray_rsp: got %h want %h", {rsp0_err, rsp0_p}, e); end
    mdl_pulse_cnt++;
    clean = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if ({rsp0_valid, rsp0_err, rsp0_p, rsp1_valid, busy, mul_start, mul_a, mul_b} !== {1'b1, 1'b0, 16'd143, 3'b000, 8'd11, 8'd13}) clean = 1'b0;
    end
    n_tests++; if (!clean) begin n_fail++; $display("FAIL stray_idle: state changed, rsp0_p=%h busy=%b mul_a=%h", rsp0_p, busy, mul_a); end
    ack_rsp(1'b1, 1'b0);
    $display("[TB] stray mul_done ignored rsp0_p=%0d", rsp0_p);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_stray_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
